// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl
// Unified instruction/data memory for the single-cycle CPU datapath.
// The instruction port is a read-only, one-cycle-latency port usable every
// cycle. The data port is a request/acknowledge port with optional wait
// states, byte-enable writes and out-of-range detection. After reset an
// optional sequencer zeroes the whole array while busy is high.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   inst_en, inst_addr    instruction read request and word address
//   inst_data, inst_valid registered instruction word and its valid flag
//   data_req, data_we     data access request (sampled in IDLE only), write flag
//   data_addr, data_wdata data word address and write data
//   data_be               byte enables, bit i covers bits 8i+7..8i
//   data_ack              one-cycle completion pulse
//   data_rdata, data_err  read data / out-of-range flag, valid with data_ack
//   busy                  clear sequence running, both ports ignored
module unified_mem_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_en,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_data,
  output logic                  inst_valid,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W/8-1:0]   data_be,
  output logic                  data_ack,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_err,
  output logic                  busy
);

  localparam int                NB        = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_ACK} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                cap_we_q, cap_we_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
  logic [NB-1:0]       cap_be_q, cap_be_d;
  logic                data_err_q, data_err_d;
  logic                data_zero_q, data_zero_d;
  logic                inst_valid_q, inst_valid_d;
  logic                inst_zero_q, inst_zero_d;

  // Access operands: with no wait states the access executes on the
  // accepting edge, so it must use the live inputs instead of the capture.
  logic                ex_we;
  logic [ADDR_W-1:0]   ex_addr;
  logic [DATA_W-1:0]   ex_wdata;
  logic [NB-1:0]       ex_be;
  logic                ex_in_range, inst_in_range, exec;

  logic                mem_we, data_rd_en, inst_rd_en;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;
  logic [DATA_W-1:0]   data_ram, inst_ram;

  always_comb begin
    if (state_q == S_IDLE) begin
      ex_we    = data_we;
      ex_addr  = data_addr;
      ex_wdata = data_wdata;
      ex_be    = data_be;
    end else begin
      ex_we    = cap_we_q;
      ex_addr  = cap_addr_q;
      ex_wdata = cap_wdata_q;
      ex_be    = cap_be_q;
    end
  end

  assign ex_in_range   = ({1'b0, ex_addr} < DEPTH_L);
  assign inst_in_range = ({1'b0, inst_addr} < DEPTH_L);

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_be_d    = cap_be_q;
    exec        = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end
      end
      S_IDLE: begin
        if (data_req) begin
          cap_we_d    = data_we;
          cap_addr_d  = data_addr;
          cap_wdata_d = data_wdata;
          cap_be_d    = data_be;
          if (WAIT_STATES == 0) begin
            exec    = 1'b1;
            state_d = S_ACK;
          end else begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == LAST_WAIT) begin
          exec    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single write port shared by the clear sequencer and the data port;
  // they never overlap because the data port is ignored during CLEAR.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = ex_addr;
    mem_wdata  = ex_wdata;
    mem_be     = ex_be;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (exec && ex_we && ex_in_range) begin
      mem_we = 1'b1;
    end
  end

  assign data_rd_en = exec && !ex_we && ex_in_range;
  assign inst_rd_en = (state_q != S_CLEAR) && inst_en && inst_in_range;

  // The RAM read registers are not reset, so zero-forcing flags decide
  // whether each output shows the RAM word or 0 (reset, write, out of range).
  always_comb begin
    data_err_d   = data_err_q;
    data_zero_d  = data_zero_q;
    inst_valid_d = inst_valid_q;
    inst_zero_d  = inst_zero_q;
    if (exec) begin
      data_err_d  = !ex_in_range;
      data_zero_d = ex_we || !ex_in_range;
    end
    if (state_q != S_CLEAR) begin
      inst_valid_d = inst_en;
      if (inst_en) inst_zero_d = !inst_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      wait_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      cap_we_q     <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      cap_be_q     <= '0;
      data_err_q   <= 1'b0;
      data_zero_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      inst_zero_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      cap_we_q     <= cap_we_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_be_q     <= cap_be_d;
      data_err_q   <= data_err_d;
      data_zero_q  <= data_zero_d;
      inst_valid_q <= inst_valid_d;
      inst_zero_q  <= inst_zero_d;
    end
  end

  // One byte-wide RAM per lane so byte enables map onto plain write enables.
  // Reads sample the old word on a same-edge write (read-before-write).
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_data_q;
    logic [7:0] lane_inst_q;

    always_ff @(posedge clk) begin
      if (mem_we && mem_be[gi]) lane_mem[mem_waddr] <= mem_wdata[8*gi +: 8];
      if (data_rd_en)           lane_data_q <= lane_mem[ex_addr];
      if (inst_rd_en)           lane_inst_q <= lane_mem[inst_addr];
    end

    assign data_ram[8*gi +: 8] = lane_data_q;
    assign inst_ram[8*gi +: 8] = lane_inst_q;
  end

  assign inst_data  = inst_zero_q ? '0 : inst_ram;
  assign inst_valid = inst_valid_q;
  assign data_rdata = data_zero_q ? '0 : data_ram;
  assign data_err   = data_err_q;
  assign data_ack   = (state_q == S_ACK);
  assign busy       = (state_q == S_CLEAR);

endmodule
